io_uart_tx: RTL and testbench

Output-side peripheral for the CPU's I/O port. It captures every 64-bit word the core stores to RAM address 0xFF, which arrives as a one-cycle `io_write` pulse with `io_data`. Captured words are buffered in a small FIFO and shifted out on a single UART line as 8N1 bytes. It is the consumer end of the core's `io_write`/`io_data` interface and needs no handshake back to the core.

---
 rtl/io_uart_tx.sv | 146 ++++++++++++++
 tb/tb_io_uart_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_uart_tx.sv
// 64-bit word UART transmitter: a FIFO of io_write words, each sent as 8N1 bytes LSB-first, byte 0 first.
// Optional build macro IO_UART_TX_NEWLINE_EN appends a framed 0x0A byte after every word.
module io_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          io_write,
    input  logic [63:0]                   io_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [1:0]                    fsm_state
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef IO_UART_TX_NEWLINE_EN
    localparam logic [3:0] LAST_BYTE = 4'd8;
`else
    localparam logic [3:0] LAST_BYTE = 4'd7;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   clk_cnt, clk_cnt_n;
    logic [2:0]         bit_idx, bit_idx_n;
    logic [3:0]         byte_idx, byte_idx_n;
    logic [63:0]        shreg, shreg_n;
    logic [63:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count_n;
    logic               full, pop, push, bit_end, tx_n, busy_n;

    assign fsm_state = state;
    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign bit_end   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push      = io_write && (!full || pop);
    assign count_n   = fifo_count + CW'(push) - CW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= io_data;
    end

    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        shreg_n    = shreg;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    shreg_n    = mem[rd_ptr];
                    byte_idx_n = 4'd0;
                    clk_cnt_n  = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    shreg_n   = {1'b0, shreg[63:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_n = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_n = IDLE;
                    end else begin
                        byte_idx_n = byte_idx + 4'd1;
                        state_n    = START;
`ifdef IO_UART_TX_NEWLINE_EN
                        // All 64 data bits have shifted out; reuse the register for the newline.
                        if (byte_idx == 4'd7) shreg_n = 64'h0A;
`endif
                    end
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx and busy are registered from next-state values so the line changes on the entering edge.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE) || (count_n != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= 3'd0;
            byte_idx   <= 4'd0;
            shreg      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            clk_cnt    <= clk_cnt_n;
            bit_idx    <= bit_idx_n;
            byte_idx   <= byte_idx_n;
            shreg      <= shreg_n;
            fifo_count <= count_n;
            tx         <= tx_n;
            busy       <= busy_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (io_write && !push) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: a free-running line decoder feeds a byte queue checked per scenario.
module tb_io_uart_tx;

`ifdef IO_UART_TX_NEWLINE_EN
    localparam int BPW      = 9;
    localparam int WORD_CYC = 360;
`else
    localparam int BPW      = 8;
    localparam int WORD_CYC = 320;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        io_write = 1'b0;
    logic [63:0] io_data = '0;
    logic        tx, busy, overflow;
    logic [2:0]  fifo_count;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];
    int         gap_q[$];

    io_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .io_write(io_write), .io_data(io_data),
        .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples mid-bit on falling clock edges; gap = negedges from last stop sample to start.
    initial begin
        int idle;
        logic [7:0] b;
        idle = 1000;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(b);
                gap_q.push_back(idle + 1);
                idle = 0;
            end else begin
                idle++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive_word(input logic [63:0] w);
        @(negedge clk);
        io_write = 1'b1;
        io_data  = w;
        @(negedge clk);
        io_write = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic get_word(input string name, input logic [63:0] exp, input int exp_gap);
        int n = 0;
        int gap_bad = 0;
        int first_gap = 0;
        logic [63:0] w = '0;
        logic [7:0] b;
        int g;
        while (rx_q.size() < BPW && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_q.size() < BPW) begin
            errors++;
            $display("FAIL %s_rx: got %0d bytes, required %0d", name, rx_q.size(), BPW);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            b = rx_q.pop_front();
            g = gap_q.pop_front();
            w[8*i +: 8] = b;
            if (i == 0) first_gap = g;
            else if (g != 2) gap_bad++;
        end
        checks++;
        if (w !== exp) begin
            errors++;
            $display("FAIL %s_word: got %h, required %h", name, w, exp);
        end
`ifdef IO_UART_TX_NEWLINE_EN
        b = rx_q.pop_front();
        g = gap_q.pop_front();
        if (g != 2) gap_bad++;
        checks++;
        if (b !== 8'h0A) begin
            errors++;
            $display("FAIL %s_newline: got %h, required 0a", name, b);
        end
`endif
        checks++;
        if (gap_bad != 0) begin
            errors++;
            $display("FAIL %s_byte_gap: %0d bad gaps, required 0", name, gap_bad);
        end
        if (exp_gap > 0) begin
            checks++;
            if (first_gap != exp_gap) begin
                errors++;
                $display("FAIL %s_word_gap: got %0d, required %0d", name, first_gap, exp_gap);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: tx=%b busy=%b count=%0d ovf=%b, required 1 0 0 0",
                         tx, busy, fifo_count, overflow);
            end
            io_write = i[0];
            io_data  = {$urandom, $urandom};
        end
        @(negedge clk);
        io_write = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: tx=%b busy=%b count=%0d, required 1 0 0", tx, busy, fifo_count);
        end
    endtask

    task automatic test_single_word();
        logic [9:0] seq = 10'b1_0100_0001_0;  // start, 0x41 LSB first, stop (bit 0 sent first)
        int t_fall, n;
        drive_word(64'h41);
        checks++;
        if (fifo_count !== 3'd1 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_push: count=%0d tx=%b, required 1 1", fifo_count, tx);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: tx=%b count=%0d busy=%b, required 0 0 1", tx, fifo_count, busy);
        end
        t_fall = cyc;
        for (int j = 0; j < 40; j++) begin
            if (j > 0) @(negedge clk);
            checks++;
            if (tx !== seq[j/4]) begin
                errors++;
                $display("FAIL single_line[%0d]: tx=%b, required %b", j, tx, seq[j/4]);
            end
        end
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc - t_fall != WORD_CYC) begin
            errors++;
            $display("FAIL single_word_time: got %0d cycles, required %0d", cyc - t_fall, WORD_CYC);
        end
        get_word("single", 64'h41, -1);
    endtask

    task automatic test_byte_order();
        drive_word(64'h8877_6655_4433_2211);
        wait_idle("byte_order");
        get_word("byte_order", 64'h8877_6655_4433_2211, -1);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                checks++;
                if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full: count=%0d ovf=%b, required 4 0", fifo_count, overflow);
                end
            end
            io_write = 1'b1;
            io_data  = 64'(i + 1);
        end
        @(negedge clk);
        io_write = 1'b0;
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: count=%0d ovf=%b, required 4 1", fifo_count, overflow);
        end
        get_word("ovf_w1", 64'd1, -1);
        for (int k = 2; k <= 5; k++) get_word($sformatf("ovf_w%0d", k), 64'(k), 3);
        wait_idle("ovf");
        repeat (60) @(negedge clk);
        checks++;
        if (rx_q.size() != 0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_extra: extra bytes=%0d ovf=%b, required 0 1", rx_q.size(), overflow);
        end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        drive_word(64'h1122_3344_00CC_BBAA);
        while (tx !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (130) @(negedge clk);  // byte 3 (0x00), data bit 1
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_before: tx=%b, required 0", tx);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: tx=%b busy=%b count=%0d ovf=%b, required 1 0 0 0",
                     tx, busy, fifo_count, overflow);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        rx_q.delete();
        gap_q.delete();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: busy=%b tx=%b, required 0 1", busy, tx);
        end
        drive_word(64'hDEAD_BEEF_0123_4567);
        wait_idle("mid_new");
        get_word("mid_new", 64'hDEAD_BEEF_0123_4567, -1);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_byte_order();
        test_overflow();
        test_reset_midframe();
        checks++;
        if (frame_err != 0) begin
            errors++;
            $display("FAIL framing: %0d bad stop bits, required 0", frame_err);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
